// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_unit_if.sv
// Start/Busy/Done handshake between the control unit (master) and the divider (slave).
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;

  modport master (
    output Start, Signed, A, B,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, Signed, A, B,
    output Busy, Done, Quotient, Remainder, DivByZero
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract |B| when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] bmag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] diff;

  // The shifted remainder needs WIDTH+1 bits; the top bit of the difference is the borrow.
  always_comb begin
    diff    = {rem_i, dvd_msb_i} - {1'b0, bmag_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], dvd_msb_i};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude load, WIDTH restoring steps, sign fix-up,
// one-cycle Done pulse. Results are held until the next division completes.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic        clk,
  input logic        rst_n,
  div_unit_if.slave  bus
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] a_mag, b_mag, step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (prem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .bmag_i    (bmag_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_comb begin
    // NOTE: every _d signal gets a default first, so no path through this block can infer a latch.
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_out_d = rem_out_q;
    dvd_d     = dvd_q;
    prem_d    = prem_q;
    bmag_d    = bmag_q;
    cnt_d     = cnt_q;

    a_mag = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          cnt_d     = '0;
          prem_d    = '0;
          neg_quo_d = bus.Signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          neg_rem_d = bus.Signed && bus.A[WIDTH-1];
          // A zero divisor skips the iterations; bmag_q==0 marks it and dvd_q keeps raw A.
          if (bus.B == '0) begin
            dvd_d   = bus.A;
            bmag_d  = '0;
            state_d = ST_FIX;
          end else begin
            dvd_d   = a_mag;
            bmag_d  = b_mag;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        prem_d = step_rem;
        dvd_d  = {dvd_q[WIDTH-2:0], step_bit};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (bmag_q == '0) begin
          quo_d     = WIDTH'(DBZ_QUOT);
          rem_out_d = dvd_q;
          dbz_d     = 1'b1;
        end else begin
          quo_d     = neg_quo_q ? -dvd_q  : dvd_q;
          rem_out_d = neg_rem_q ? -prem_q : prem_q;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_out_q <= '0;
      dvd_q     <= '0;
      prem_q    <= '0;
      bmag_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_out_q <= rem_out_d;
      dvd_q     <= dvd_d;
      prem_q    <= prem_d;
      bmag_q    <= bmag_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_out_q;
  assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases from the plan plus random
// divisions, compared every cycle against a transaction-level reference model.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {div_by_zero, quotient, remainder} from plain integer arithmetic.
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Transaction model: accept in idle, complete after a fixed latency, then one dead cycle.
  logic        m_busy, m_done, m_dbz, p_dbz;
  logic [31:0] m_q, m_r, p_q, p_r;
  int          m_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_q    <= 32'd0;
      m_r    <= 32'd0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= p_q;
        m_r    <= p_r;
        m_dbz  <= p_dbz;
      end
      m_left <= m_left - 1;
    end else if (bus.Start) begin
      m_busy <= 1'b1;
      m_dbz  <= 1'b0;
      m_left <= (bus.B == 32'd0) ? 1 : 33;
      {p_dbz, p_q, p_r} <= ref_div(bus.A, bus.B, bus.Signed);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.Busy), 32'(m_busy));
      check("done", 32'(bus.Done), 32'(m_done));
      check("dbz", 32'(bus.DivByZero), 32'(m_dbz));
      check("quotient", bus.Quotient, m_q);
      check("remainder", bus.Remainder, m_r);
    end
  end

  // One division: fixed 60-cycle window, optional ignored Start pulses and a reset pulse.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int inj1, input int inj2, input int rst_at,
                         output int lat, output int busy_n, output int dones);
    lat    = 0;
    busy_n = 0;
    dones  = 0;
    @(negedge clk);
    bus.A      = a;
    bus.B      = b;
    bus.Signed = s;
    bus.Start  = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.Start = 1'b0;
      rst_n     = 1'b1;
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        dones++;
        if (lat == 0) lat = c;
      end
      if (c == inj1 || c == inj2) begin
        bus.Start  = 1'b1;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.Signed = 1'($urandom_range(0, 1));
      end
      if (c == rst_at) rst_n = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 19));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat, bn, dn;
    logic [31:0] a, b;
    logic        s;

    rst_n      = 1'b0;
    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_quot", bus.Quotient, 32'd0);
    check("rst_rem", bus.Remainder, 32'd0);
    rst_n = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 0, 0, 0, lat, bn, dn);
    check("u100_7_lat", 32'(lat), 32'd34);
    check("u100_7_busy", 32'(bn), 32'd33);
    check("u100_7_dones", 32'(dn), 32'd1);
    check("u100_7_q", bus.Quotient, 32'd14);
    check("u100_7_r", bus.Remainder, 32'd2);
    check("u100_7_dbz", 32'(bus.DivByZero), 32'd0);

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 0, lat, bn, dn);
    check("sm7_2_q", bus.Quotient, 32'hFFFF_FFFD);
    check("sm7_2_r", bus.Remainder, 32'hFFFF_FFFF);

    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0, 0, lat, bn, dn);
    check("s7_m2_q", bus.Quotient, 32'hFFFF_FFFD);
    check("s7_m2_r", bus.Remainder, 32'd1);

    for (int m = 0; m < 2; m++) begin
      run_div(32'd5, 32'd0, 1'(m), 0, 0, 0, lat, bn, dn);
      check("dbz_lat", 32'(lat), 32'd2);
      check("dbz_q", bus.Quotient, 32'hFFFF_FFFF);
      check("dbz_r", bus.Remainder, 32'd5);
      check("dbz_flag", 32'(bus.DivByZero), 32'd1);
    end
    run_div(32'd100, 32'd7, 1'b1, 0, 0, 0, lat, bn, dn);
    check("dbz_cleared", 32'(bus.DivByZero), 32'd0);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, lat, bn, dn);
    check("ovf_q", bus.Quotient, 32'h8000_0000);
    check("ovf_r", bus.Remainder, 32'd0);
    check("ovf_dbz", 32'(bus.DivByZero), 32'd0);

    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0, lat, bn, dn);
    check("umax_q", bus.Quotient, 32'hFFFF_FFFF);
    check("umax_r", bus.Remainder, 32'd0);

    run_div(32'd100, 32'd7, 1'b0, 5, 20, 0, lat, bn, dn);
    check("inj_dones", 32'(dn), 32'd1);
    check("inj_q", bus.Quotient, 32'd14);
    check("inj_r", bus.Remainder, 32'd2);

    run_div(32'd100, 32'd7, 1'b0, 0, 0, 10, lat, bn, dn);
    check("rst_mid_dones", 32'(dn), 32'd0);
    check("rst_mid_busy", 32'(bus.Busy), 32'd0);
    check("rst_mid_q", bus.Quotient, 32'd0);
    check("rst_mid_r", bus.Remainder, 32'd0);

    run_div(32'd9, 32'd3, 1'b0, 0, 0, 0, lat, bn, dn);
    check("r9_3_lat", 32'(lat), 32'd34);
    check("r9_3_q", bus.Quotient, 32'd3);
    check("r9_3_r", bus.Remainder, 32'd0);

    for (int i = 0; i < 30; i++) begin
      a = pick_operand();
      b = pick_operand();
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, 0, 0, 0, lat, bn, dn);
      check("rand_lat", 32'(lat), (b == 32'd0) ? 32'd2 : 32'd34);
      check("rand_dones", 32'(dn), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
